// File: rtl/mhp_tx.sv
// MHP frame transmitter: emits header, buffered payload, 16-bit simple checksum
// and zero padding over a byte handshake, one byte per two cycles at most.
module mhp_tx #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MIN_FRAME = 46
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [7:0]        i_ld_data,
  input  logic              i_send,
  input  logic [15:0]       i_dst,
  input  logic [15:0]       i_src,
  input  logic [ADDR_W:0]   i_size,
  input  logic              i_dir,
  input  logic [6:0]        i_type,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_wready,
  output logic              o_wvalid,
  output logic [7:0]        o_wdata
);

  localparam int unsigned IDX_W = ADDR_W + 2;
  localparam int unsigned SZ_W  = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0] HDR_LEN = IDX_W'(7);
  localparam logic [IDX_W-1:0] MIN_LEN = IDX_W'(MIN_FRAME);

  logic [1:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [15:0]      scs, scs_d;
  logic [15:0]      dst_q, dst_d;
  logic [15:0]      src_q, src_d;
  logic [SZ_W-1:0]  size_q, size_d;
  logic [7:0]       dtype_q, dtype_d;
  logic             busy_d, done_d, wvalid_d;
  logic [7:0]       wdata_d;

  logic [7:0]       mem [DEPTH];
  logic [7:0]       rd_data;

  logic [SZ_W-1:0]  size_clamp_c;
  logic [IDX_W-1:0] pay_end_c;
  logic [IDX_W-1:0] frame_len_c;
  logic [IDX_W-1:0] total_c;
  logic [15:0]      size16_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [7:0]       byte_c;
  logic             in_sum_c;
  logic             frozen_c;

  // Oversized requests saturate to the full buffer depth.
  assign size_clamp_c = i_size[ADDR_W] ? SZ_W'(DEPTH) : i_size;
  assign pay_end_c    = HDR_LEN + IDX_W'(size_q);
  assign frame_len_c  = pay_end_c + IDX_W'(2);
  assign total_c      = (frame_len_c < MIN_LEN) ? MIN_LEN : frame_len_c;
  assign size16_c     = 16'(size_q);
  assign rd_addr_c    = ADDR_W'(idx - HDR_LEN);
  assign in_sum_c     = (idx < pay_end_c);
  assign frozen_c     = (state == S_EMIT) || (state == S_GAP);

  // Byte source select by position in the frame.
  always_comb begin
    byte_c = 8'h00;
    if (idx < HDR_LEN) begin
      case (idx[2:0])
        3'd0:    byte_c = dst_q[15:8];
        3'd1:    byte_c = dst_q[7:0];
        3'd2:    byte_c = src_q[15:8];
        3'd3:    byte_c = src_q[7:0];
        3'd4:    byte_c = size16_c[15:8];
        3'd5:    byte_c = size16_c[7:0];
        default: byte_c = dtype_q;
      endcase
    end else if (idx < pay_end_c) begin
      byte_c = rd_data;
    end else if (idx == pay_end_c) begin
      byte_c = scs[15:8];
    end else if (idx == pay_end_c + IDX_W'(1)) begin
      byte_c = scs[7:0];
    end
  end

  // Payload buffer; read is issued in GAP so the data is ready for the next EMIT.
  always_ff @(posedge i_clk) begin
    if (i_ld_we && !frozen_c) begin
      mem[i_ld_addr] <= i_ld_data;
    end
    if (state == S_GAP) begin
      rd_data <= mem[rd_addr_c];
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    scs_d    = scs;
    dst_d    = dst_q;
    src_d    = src_q;
    size_d   = size_q;
    dtype_d  = dtype_q;
    wvalid_d = 1'b0;
    wdata_d  = o_wdata;
    case (state)
      S_IDLE: begin
        if (i_send) begin
          dst_d   = i_dst;
          src_d   = i_src;
          size_d  = size_clamp_c;
          dtype_d = {i_dir, i_type};
          idx_d   = '0;
          scs_d   = 16'h0000;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (i_wready) begin
          wvalid_d = 1'b1;
          wdata_d  = byte_c;
          if (in_sum_c) begin
            scs_d = scs + 16'(byte_c);
          end
          idx_d   = idx + IDX_W'(1);
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = (idx == total_c) ? S_DONE : S_EMIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_EMIT) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      scs      <= 16'h0000;
      dst_q    <= 16'h0000;
      src_q    <= 16'h0000;
      size_q   <= '0;
      dtype_q  <= 8'h00;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_wvalid <= 1'b0;
      o_wdata  <= 8'h00;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      scs      <= scs_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      size_q   <= size_d;
      dtype_q  <= dtype_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
      o_wvalid <= wvalid_d;
      o_wdata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mhp_tx.sv
// Randomized scoreboard bench for mhp_tx: expected frames are built from the
// frame format rules and checked byte by byte by an independent monitor.
module tb_mhp_tx;
  localparam int ADDR_W = 10;
  localparam int MIN_FRAME = 46;
  localparam int DEPTH = 1 << ADDR_W;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_ld_we = 1'b0;
  logic [ADDR_W-1:0] i_ld_addr = '0;
  logic [7:0]        i_ld_data = 8'h00;
  logic              i_send = 1'b0;
  logic [15:0]       i_dst = 16'h0000;
  logic [15:0]       i_src = 16'h0000;
  logic [ADDR_W:0]   i_size = '0;
  logic              i_dir = 1'b0;
  logic [6:0]        i_type = 7'h00;
  logic              o_busy, o_done;
  logic              i_wready = 1'b1;
  logic              o_wvalid;
  logic [7:0]        o_wdata;

  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_q[$];
  int   exp_done = 0;
  int   tb_mem [DEPTH];
  int   wr_mode = 0;
  logic wr_at_edge = 1'b1;
  logic prev_wv = 1'b0;

  mhp_tx #(.ADDR_W(ADDR_W), .MIN_FRAME(MIN_FRAME)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr),
    .i_ld_data(i_ld_data), .i_send(i_send), .i_dst(i_dst), .i_src(i_src),
    .i_size(i_size), .i_dir(i_dir), .i_type(i_type), .o_busy(o_busy),
    .o_done(o_done), .i_wready(i_wready), .o_wvalid(o_wvalid), .o_wdata(o_wdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge i_clk) wr_at_edge <= i_wready;

  // Ready generator: 0 = always ready, 1 = stalled, 2 = random.
  initial forever begin
    @(posedge i_clk);
    #1;
    case (wr_mode)
      0:       i_wready = 1'b1;
      1:       i_wready = 1'b0;
      default: i_wready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard whenever a byte or done pulse appears.
  initial forever begin
    @(negedge i_clk);
    if (i_rst) begin
      if (o_wvalid) begin
        chk("wvalid_back_to_back", int'(prev_wv), 0);
        chk("wvalid_without_ready", int'(wr_at_edge), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", int'(o_wdata), -1);
        end else begin
          chk("frame_byte", int'(o_wdata), exp_q.pop_front());
        end
      end
      if (o_done) begin
        chk("done_expected", int'(exp_done > 0), 1);
        chk("done_bytes_left", exp_q.size(), 0);
        if (exp_done > 0) exp_done--;
      end
      prev_wv = o_wvalid;
    end else begin
      prev_wv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input int addr, input int data);
    i_ld_we = 1'b1;
    i_ld_addr = ADDR_W'(addr);
    i_ld_data = 8'(data);
    tb_mem[addr] = data & 8'hFF;
    tick();
    i_ld_we = 1'b0;
  endtask

  // Reference frame from the wire-format rules.
  task automatic push_frame(input int dst, input int src, input int size,
                            input int dir, input int typ);
    int sz, sum, cnt;
    int b[$];
    sz = (size > DEPTH) ? DEPTH : size;
    b.push_back((dst >> 8) & 255);
    b.push_back(dst & 255);
    b.push_back((src >> 8) & 255);
    b.push_back(src & 255);
    b.push_back((sz >> 8) & 255);
    b.push_back(sz & 255);
    b.push_back(((dir & 1) << 7) | (typ & 127));
    for (int k = 0; k < sz; k++) b.push_back(tb_mem[k]);
    sum = 0;
    foreach (b[k]) sum = (sum + b[k]) % 65536;
    b.push_back(sum >> 8);
    b.push_back(sum & 255);
    cnt = b.size();
    while (cnt < MIN_FRAME) begin
      b.push_back(0);
      cnt++;
    end
    foreach (b[k]) exp_q.push_back(b[k]);
    exp_done++;
  endtask

  task automatic send(input int dst, input int src, input int size, input int dir,
                      input int typ, input bit col_we, input int col_addr, input int col_data);
    i_send = 1'b1;
    i_dst = 16'(dst);
    i_src = 16'(src);
    i_size = (ADDR_W + 1)'(size);
    i_dir = 1'(dir);
    i_type = 7'(typ);
    if (col_we) begin
      i_ld_we = 1'b1;
      i_ld_addr = ADDR_W'(col_addr);
      i_ld_data = 8'(col_data);
      tb_mem[col_addr] = col_data & 255;
    end
    push_frame(dst & 16'hFFFF, src & 16'hFFFF, size, dir, typ);
    tick();
    i_send = 1'b0;
    i_ld_we = 1'b0;
    i_dst = 16'($urandom);
    i_src = 16'($urandom);
    i_size = (ADDR_W + 1)'($urandom);
    i_dir = 1'($urandom);
    i_type = 7'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && exp_done == 0 && !o_busy && !o_done) && n < 6000) begin
      tick();
      n++;
    end
    chk("frame_timeout", int'(n < 6000), 1);
  endtask

  task automatic do_reset_check(input string name);
    @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    #1;
    chk({name, "_busy"}, int'(o_busy), 0);
    chk({name, "_done"}, int'(o_done), 0);
    chk({name, "_wvalid"}, int'(o_wvalid), 0);
    chk({name, "_wdata"}, int'(o_wdata), 0);
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) tb_mem[k] = 0;
    #2;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_wvalid", int'(o_wvalid), 0);
    chk("rst_wdata", int'(o_wdata), 0);
    repeat (2) tick();
    i_rst = 1'b1;
    tick();
    // Buffer contents are unknown after power-up; give the model a defined image.
    for (int k = 0; k < 64; k++) load(k, 0);

    load(0, 8'hAA); load(1, 8'hBB); load(2, 8'hCC);
    send(16'h1234, 16'h0001, 3, 1, 5, 1'b0, 0, 0);
    wait_idle();

    for (int k = 0; k < 37; k++) load(k, int'($urandom_range(0, 255)));
    send(int'($urandom), int'($urandom), 37, 0, 7'h2A, 1'b0, 0, 0);
    wait_idle();

    send(0, 0, 0, 0, 0, 1'b0, 0, 0);
    wait_idle();

    for (int k = 0; k < DEPTH; k++) load(k, 8'hFF);
    send(16'hFFFF, 16'hFFFF, 1024, 1, 7'h7F, 1'b0, 0, 0);
    wait_idle();

    for (int k = 0; k < DEPTH; k++) load(k, int'($urandom_range(0, 255)));
    send(16'hBEEF, 16'h0102, 2047, 0, 3, 1'b0, 0, 0);
    wait_idle();

    // Long stall mid-payload, then random ready.
    send(16'hA5A5, 16'h5A5A, 40, 1, 9, 1'b0, 0, 0);
    repeat (30) tick();
    wr_mode = 1;
    repeat (10) tick();
    wr_mode = 2;
    wait_idle();
    wr_mode = 0;

    // Requests and writes during a frame must have no effect.
    send(16'h0F0F, 16'hF0F0, 20, 0, 1, 1'b0, 0, 0);
    for (int c = 0; c < 40; c++) begin
      i_send = 1'b0;
      i_ld_we = 1'b0;
      if (o_busy && $urandom_range(0, 2) == 0) begin
        i_send = 1'b1;
        i_ld_we = 1'b1;
        i_ld_addr = ADDR_W'($urandom_range(0, 19));
        i_ld_data = 8'($urandom);
      end
      tick();
    end
    i_send = 1'b0;
    i_ld_we = 1'b0;
    wait_idle();
    send(16'h0001, 16'h0002, 5, 1, 2, 1'b0, 0, 0);
    wait_idle();

    // Write in the same cycle as send lands before the payload read.
    send(16'h4444, 16'h5555, 4, 0, 6, 1'b1, 1, 8'h3C);
    wait_idle();

    do_reset_check("idle_rst");
    send(16'h7777, 16'h8888, 60, 1, 4, 1'b0, 0, 0);
    repeat (25) tick();
    do_reset_check("frame_rst");
    repeat (5) tick();
    send(16'h1357, 16'h2468, 12, 0, 11, 1'b0, 0, 0);
    wait_idle();

    for (int f = 0; f < 4; f++) begin
      wr_mode = 2;
      send(int'($urandom), int'($urandom), int'($urandom_range(0, 80)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 127)), 1'b0, 0, 0);
      wait_idle();
    end
    wr_mode = 0;
    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_done_count", exp_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
